// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI-to-memory bridge: opcodes, FSM states and
// address-sequencing helpers used by both the bridge and its bench.
package spi_mem_pkg;

  localparam logic [1:0] OPC_WR = 2'b00;
  localparam logic [1:0] OPC_RD = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    START,
    OPC,
    ADDR,
    WDATA,
    RWAIT,
    RDATA,
    DROP
  } state_e;

  // Burst address sequence: wrap to 0 after the last implemented word,
  // otherwise step by one (the caller truncates to the address width).
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [31:0] depth);
    return (a == depth - 32'd1) ? 32'd0 : a + 32'd1;
  endfunction

  // True when the address maps onto an implemented memory word.
  function automatic logic addr_in_range(input logic [31:0] a, input logic [31:0] depth);
    return a < depth;
  endfunction

endpackage

// File: rtl/spi_mem_bridge_if.sv
// Serial pin bundle of the bridge: the external SPI master drives MOSI/SS_n,
// the bridge drives MISO and its frame-in-progress flag.
interface spi_mem_bridge_if;

  logic MOSI;
  logic SS_n;
  logic MISO;
  logic busy;

  modport master (
    output MOSI,
    output SS_n,
    input  MISO,
    input  busy
  );

  modport slave (
    input  MOSI,
    input  SS_n,
    output MISO,
    output busy
  );

endinterface

// File: rtl/spi_mem_array.sv
// Single-port word memory: synchronous write, registered read with one cycle
// of latency, no reset so it maps onto block RAM.
module spi_mem_array #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]  idx;

  // Out-of-range addresses are filtered by the bridge (writes gated, read
  // data masked), so only the low index bits are needed here.
  assign idx = IDX_W'(addr);

  // Write port plus registered read of the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave front end that decodes framed burst-write / burst-read commands
// into accesses of an internal single-port memory, streaming read data on
// MISO without gaps between consecutive words.
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_mem_bridge_if.slave  spi
);

  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_e              state_reg, state_next;
  logic                busy_reg, busy_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic                opc_msb_reg, opc_msb_next;
  logic                is_rd_reg, is_rd_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   rx_reg, rx_next;
  logic [DATA_W-1:0]   tx_reg, tx_next;
  logic [DATA_W-1:0]   pf_reg, pf_next;
  logic                rd_oob_reg;

  logic [1:0]          opc_word;
  logic [ADDR_W-1:0]   addr_inc;
  logic [DATA_W-1:0]   rx_shift;
  logic [DATA_W-1:0]   rd_word;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  assign opc_word = {opc_msb_reg, spi.MOSI};
  assign addr_inc = ADDR_W'(next_addr(32'(addr_reg), 32'(MEM_DEPTH)));
  assign rx_shift = DATA_W'({rx_reg, spi.MOSI});
  assign rd_word  = rd_oob_reg ? '0 : ram_rdata;

  // tx_reg is all-zero whenever no word is streaming, so its MSB is MISO.
  assign spi.MISO = tx_reg[DATA_W-1];
  assign spi.busy = busy_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; a deselected frame always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    if (spi.SS_n) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  state_next = START;
        START: state_next = OPC;
        OPC:   state_next = (opc_word == OPC_WR || opc_word == OPC_RD) ? ADDR : DROP;
        ADDR:  if (bit_cnt_reg == ADDR_LAST) state_next = is_rd_reg ? RWAIT : WDATA;
        WDATA: state_next = WDATA;
        RWAIT: state_next = RDATA;
        RDATA: state_next = RDATA;
        DROP:  state_next = DROP;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath and memory-port control for the current state.
  always_comb begin
    busy_next    = (state_next != IDLE);
    bit_cnt_next = bit_cnt_reg;
    opc_msb_next = opc_msb_reg;
    is_rd_next   = is_rd_reg;
    addr_next    = addr_reg;
    rx_next      = rx_reg;
    tx_next      = '0;
    pf_next      = pf_reg;
    ram_we       = 1'b0;
    ram_wdata    = rx_shift;
    if (spi.SS_n) begin
      // Frame ended: drop any partial word and restart from scratch.
      bit_cnt_next = '0;
      opc_msb_next = 1'b0;
      is_rd_next   = 1'b0;
      addr_next    = '0;
      rx_next      = '0;
      pf_next      = '0;
    end else begin
      case (state_reg)
        START: begin
          opc_msb_next = spi.MOSI;
        end
        OPC: begin
          is_rd_next   = (opc_word == OPC_RD);
          bit_cnt_next = '0;
        end
        ADDR: begin
          // The final shift also presents the start address to the RAM so
          // the first read word is ready by the RWAIT edge.
          addr_next    = ADDR_W'({addr_reg, spi.MOSI});
          bit_cnt_next = (bit_cnt_reg == ADDR_LAST) ? '0 : bit_cnt_reg + CNT_W'(1);
        end
        WDATA: begin
          if (bit_cnt_reg == DATA_LAST) begin
            ram_we       = addr_in_range(32'(addr_reg), 32'(MEM_DEPTH));
            addr_next    = addr_inc;
            rx_next      = '0;
            bit_cnt_next = '0;
          end else begin
            rx_next      = rx_shift;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
        RWAIT: begin
          // Load word 0 and start fetching word 1 in the same edge.
          tx_next      = rd_word;
          addr_next    = addr_inc;
          bit_cnt_next = '0;
        end
        RDATA: begin
          if (bit_cnt_reg == DATA_LAST) begin
            tx_next      = pf_reg;
            addr_next    = addr_inc;
            bit_cnt_next = '0;
          end else begin
            tx_next      = tx_reg << 1;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
          // RAM output settles one cycle after each fetch is issued.
          if (bit_cnt_reg == '0) begin
            pf_next = rd_word;
          end
        end
        default: ;
      endcase
    end
    ram_addr = ram_we ? addr_reg : addr_next;
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg    <= 1'b0;
      bit_cnt_reg <= '0;
      opc_msb_reg <= 1'b0;
      is_rd_reg   <= 1'b0;
      addr_reg    <= '0;
      rx_reg      <= '0;
      tx_reg      <= '0;
      pf_reg      <= '0;
      rd_oob_reg  <= 1'b0;
    end else begin
      busy_reg    <= busy_next;
      bit_cnt_reg <= bit_cnt_next;
      opc_msb_reg <= opc_msb_next;
      is_rd_reg   <= is_rd_next;
      addr_reg    <= addr_next;
      rx_reg      <= rx_next;
      tx_reg      <= tx_next;
      pf_reg      <= pf_next;
      rd_oob_reg  <= !addr_in_range(32'(ram_addr), 32'(MEM_DEPTH));
    end
  end

  spi_mem_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: one default-sized instance and one with
// MEM_DEPTH=200, each driven frame by frame from a bit-level master model.
module tb_spi_mem_bridge;
  import spi_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic mosi;
  logic ss_def;
  logic ss_200;
  int   sel;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spi_mem_bridge_if if_def ();
  spi_mem_bridge_if if_200 ();

  assign if_def.MOSI = mosi;
  assign if_def.SS_n = ss_def;
  assign if_200.MOSI = mosi;
  assign if_200.SS_n = ss_200;

  spi_mem_bridge u_def (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (if_def)
  );

  spi_mem_bridge #(
    .DATA_W    (8),
    .ADDR_W    (8),
    .MEM_DEPTH (200)
  ) u_d200 (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (if_200)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One master edge: sample what the slave presents for the coming rising
  // edge, then set up SS_n/MOSI for it on the selected instance.
  task automatic clk_edge(input logic ss_v, input logic mosi_v, output logic miso_s, output logic busy_s);
    @(negedge clk);
    miso_s = (sel != 0) ? if_200.MISO : if_def.MISO;
    busy_s = (sel != 0) ? if_200.busy : if_def.busy;
    mosi   = mosi_v;
    if (sel != 0) begin
      ss_200 = ss_v;
      ss_def = 1'b1;
    end else begin
      ss_def = ss_v;
      ss_200 = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic m, b;
    for (int i = n - 1; i >= 0; i--) begin
      clk_edge(1'b0, v[i], m, b);
    end
  endtask

  // Edge 0, opcode on edges 1-2, address on edges 3-10.
  task automatic frame_head(input logic [1:0] opc, input logic [7:0] a, output logic busy_s);
    logic m, b;
    clk_edge(1'b0, 1'b0, m, b);
    clk_edge(1'b0, opc[1], m, busy_s);
    clk_edge(1'b0, opc[0], m, b);
    send_bits(32'(a), 8);
  endtask

  task automatic frame_end(output logic busy_before, output logic busy_after, output logic miso_after);
    logic m;
    clk_edge(1'b1, 1'b0, m, busy_before);
    clk_edge(1'b1, 1'b0, miso_after, busy_after);
  endtask

  task automatic write_frame(input string tag, input logic [7:0] a, input logic [31:0] words,
                             input int n_words, input int extra_bits);
    logic b1, bb, ba, ma;
    frame_head(OPC_WR, a, b1);
    for (int w = 0; w < n_words; w++) begin
      send_bits(32'(words[31-8*w -: 8]), 8);
    end
    if (extra_bits > 0) begin
      send_bits(32'(words[31-8*n_words -: 8]) >> (8 - extra_bits), extra_bits);
    end
    frame_end(bb, ba, ma);
    $display("wr dut=%0d addr=%02h words=%0d partial_bits=%0d data=%08h", sel, a, n_words, extra_bits, words);
    check_eq($sformatf("%s_busy_rise", tag), 32'(b1), 32'd1);
    check_eq($sformatf("%s_busy_hold", tag), 32'(bb), 32'd1);
    check_eq($sformatf("%s_busy_fall", tag), 32'(ba), 32'd0);
  endtask

  task automatic read_frame(input string tag, input logic [7:0] a, input int n_words, input logic [31:0] exp);
    logic b1, bb, ba, ma, m, b;
    logic [31:0] got;
    frame_head(OPC_RD, a, b1);
    clk_edge(1'b0, 1'b0, m, b);
    got = '0;
    for (int i = 0; i < 8 * n_words; i++) begin
      clk_edge(1'b0, 1'b0, m, b);
      got = {got[30:0], m};
    end
    frame_end(bb, ba, ma);
    $display("rd dut=%0d addr=%02h words=%0d got=%0h exp=%0h", sel, a, n_words, got, exp);
    check_eq(tag, got, exp);
    check_eq($sformatf("%s_miso_idle", tag), 32'(ma), 32'd0);
    check_eq($sformatf("%s_busy_fall", tag), 32'(ba), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m, b, bb, ba, ma, miso_or;
    logic [31:0] got;
    logic [31:0] drop_pat;

    rst_n  = 1'b0;
    mosi   = 1'b0;
    ss_def = 1'b1;
    ss_200 = 1'b1;
    sel    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy_def", 32'(if_def.busy), 32'd0);
    check_eq("rst_miso_def", 32'(if_def.MISO), 32'd0);
    check_eq("rst_busy_200", 32'(if_200.busy), 32'd0);
    check_eq("rst_miso_200", 32'(if_200.MISO), 32'd0);

    // Basic burst write then gap-free burst read on the default instance.
    sel = 0;
    write_frame("t1_wr", 8'h10, 32'hA53C_0000, 2, 0);
    read_frame("t1_rd", 8'h10, 2, 32'h0000_A53C);

    // Address wrap at MEM_DEPTH-1 on the 200-word instance.
    sel = 1;
    write_frame("t2_wr", 8'd198, 32'h1122_3300, 3, 0);
    read_frame("t2_rd198", 8'd198, 3, 32'h0011_2233);
    read_frame("t2_rd199", 8'd199, 2, 32'h0000_2233);
    read_frame("t2_rd0", 8'd0, 1, 32'h0000_0033);

    // Unimplemented addresses: write dropped, read returns zero.
    write_frame("t3_wr_oob", 8'hF0, 32'h7700_0000, 1, 0);
    read_frame("t3_rd_oob", 8'hF0, 1, 32'h0000_0000);
    read_frame("t3_rd0_keep", 8'd0, 1, 32'h0000_0033);
    sel = 0;
    write_frame("t3_wr_def", 8'hF0, 32'h7700_0000, 1, 0);
    read_frame("t3_rd_def", 8'hF0, 1, 32'h0000_0077);

    // Frame aborted after 5 bits of word 2: that word must not be written.
    write_frame("t4_pre", 8'h42, 32'h9900_0000, 1, 0);
    write_frame("t4_wr", 8'h40, 32'h5A6B_7C00, 2, 5);
    read_frame("t4_rd", 8'h40, 3, 32'h005A_6B99);

    // Reserved opcode: payload that would overwrite 0x10/0x11 if decoded.
    drop_pat = 32'h10FF_00C3;
    clk_edge(1'b0, 1'b0, m, b);
    clk_edge(1'b0, 1'b1, m, b);
    clk_edge(1'b0, 1'b0, m, b);
    miso_or = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      clk_edge(1'b0, drop_pat[i], m, b);
      miso_or = miso_or | m;
    end
    frame_end(bb, ba, ma);
    miso_or = miso_or | ma;
    $display("drop dut=%0d opc=10 payload=%08h miso_or=%0d", sel, drop_pat, miso_or);
    check_eq("t5_drop_miso", 32'(miso_or), 32'd0);
    check_eq("t5_drop_busy_fall", 32'(ba), 32'd0);
    read_frame("t5_rd_after", 8'h10, 2, 32'h0000_A53C);

    // Asynchronous reset in the middle of a read stream.
    frame_head(OPC_RD, 8'h10, b);
    clk_edge(1'b0, 1'b0, m, b);
    got = '0;
    for (int i = 0; i < 5; i++) begin
      clk_edge(1'b0, 1'b0, m, b);
      got = {got[30:0], m};
    end
    check_eq("t6_partial_bits", got, 32'h0000_0014);
    @(negedge clk);
    #1;
    check_eq("t6_miso_before_rst", 32'(if_def.MISO), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_miso_in_rst", 32'(if_def.MISO), 32'd0);
    check_eq("t6_busy_in_rst", 32'(if_def.busy), 32'd0);
    $display("rst dut=%0d asserted mid-stream after 6 bits", sel);
    ss_def = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_frame("t6_wr", 8'h20, 32'hC300_0000, 1, 0);
    read_frame("t6_rd", 8'h20, 1, 32'h0000_00C3);
    read_frame("t6_rd_keep", 8'h10, 2, 32'h0000_A53C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
